// File: rtl/fetch_pc_register.sv
// Program counter and IF/ID pipeline register for the single-issue MIPS
// front end. Selects the next fetch address from the sequential PC+4,
// a taken branch or a jump, and applies stall / flush to IF/ID.
module fetch_pc_register #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCAddResult,
   input  logic [31:0] Instruction,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        Stall,
   input  logic        Flush,
   output logic [31:0] PCResult,
   output logic [31:0] IFID_PCAdd,
   output logic [31:0] IFID_Instruction,
   output logic        IFID_Valid,
   output logic        AlignFault,
   output logic [31:0] FetchCount
);

   logic        redirect;
   logic [31:0] redirect_target;
   logic        redirect_misaligned;
   logic        load_bubble;
   logic        accept;

   // Decode this cycle's control inputs into redirect / bubble / accept.
   always_comb begin
      redirect            = Jump | BranchTaken;
      // Jump wins over a simultaneous taken branch.
      redirect_target     = Jump ? JumpTarget : BranchTarget;
      redirect_misaligned = redirect && (redirect_target[1:0] != 2'b00);
      // A redirect or an explicit flush squashes whatever is being fetched,
      // even while stalled.
      load_bubble         = redirect | Flush;
      // Only an unstalled, unredirected, unflushed fetch enters IF/ID.
      accept              = !redirect && !Stall && !Flush;
   end

   // PC, IF/ID, fault pulse and fetch counter state.
   always_ff @(posedge Clk) begin
      // NOTE: every register here uses non-blocking assignment so all state
      // samples pre-edge values regardless of statement order.
      if (Reset) begin
         PCResult         <= RESET_PC;
         IFID_PCAdd       <= 32'h0000_0000;
         IFID_Instruction <= NOP_INSTR;
         IFID_Valid       <= 1'b0;
         AlignFault       <= 1'b0;
         FetchCount       <= 32'h0000_0000;
      end else begin
         AlignFault <= redirect_misaligned;

         // Redirect targets are forced word aligned; a stall holds the PC.
         if (redirect) begin
            PCResult <= {redirect_target[31:2], 2'b00};
         end else if (!Stall) begin
            PCResult <= {PCAddResult[31:2], 2'b00};
         end

         if (load_bubble) begin
            IFID_PCAdd       <= 32'h0000_0000;
            IFID_Instruction <= NOP_INSTR;
            IFID_Valid       <= 1'b0;
         end else if (accept) begin
            IFID_PCAdd       <= PCAddResult;
            IFID_Instruction <= Instruction;
            IFID_Valid       <= 1'b1;
         end

         if (accept) begin
            FetchCount <= FetchCount + 32'd1;
         end
      end
   end

endmodule

// File: doc/fetch_pc_register.md
Name: fetch_pc_register

Overview:
Program-counter register and IF/ID boundary for the single-issue MIPS pipeline. It drives the current fetch address to the PC adder and instruction memory, and takes the adder's PC+4 result back as the sequential next PC. It selects the next PC from sequential, branch or jump sources, and applies stall and flush to the IF/ID pipeline register it owns.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000000, instruction word inserted into IF/ID on a bubble (sll $0,$0,0)

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
PCAddResult  input  32  PC+4 from the PC adder
Instruction  input  32  instruction memory read data for address PCResult
BranchTaken  input  1  branch resolved taken this cycle
BranchTarget  input  32  branch target address
Jump  input  1  jump (j/jal/jr) redirect this cycle
JumpTarget  input  32  jump target address
Stall  input  1  hold PC and IF/ID (load-use hazard)
Flush  input  1  replace IF/ID contents with a bubble
PCResult  output  32  current fetch address
IFID_PCAdd  output  32  PC+4 of the instruction held in IF/ID
IFID_Instruction  output  32  instruction held in IF/ID
IFID_Valid  output  1  IF/ID holds a real instruction
AlignFault  output  1  one-cycle pulse: redirect target had nonzero bits [1:0]
FetchCount  output  32  count of instructions accepted into IF/ID

Behaviour:
- One clock (Clk). Reset is synchronous and active-high; all state updates on the rising edge of Clk.
- Reset values: PCResult=RESET_PC, IFID_PCAdd=0, IFID_Instruction=NOP_INSTR, IFID_Valid=0, AlignFault=0, FetchCount=0. Reset overrides every other input. Reset asserted mid-stall or mid-redirect discards that state.
- All outputs are registered. PCResult changes only at clock edges, and combinational input changes never reach the outputs in the same cycle.
- Per-edge priority, highest first:
  1. Reset
  2. Jump
  3. BranchTaken
  4. Stall
  5. Sequential
- Jump: PCResult<={JumpTarget[31:2],2'b00}. IF/ID<=bubble (IFID_Instruction=NOP_INSTR, IFID_Valid=0, IFID_PCAdd=0). FetchCount unchanged. Jump takes priority when asserted together with BranchTaken.
- BranchTaken (no Jump): same as Jump, using BranchTarget.
- A redirect overrides Stall: the PC loads the target even when Stall=1.
- Stall (no redirect): PCResult, IFID_* and FetchCount hold.
- Sequential: PCResult<=PCAddResult; IFID_Instruction<=Instruction; IFID_PCAdd<=PCAddResult; IFID_Valid<=1; FetchCount<=FetchCount+1.
- Flush: forces the IF/ID bubble on this edge and does not increment FetchCount. The PC updates per the priority list: Flush+Stall holds the PC; Flush alone advances the PC sequentially.
- AlignFault: registered. It is 1 for exactly the cycle after an edge where the selected redirect target had bits[1:0]!=0, and 0 otherwise. The target is still loaded with its low bits cleared.
- Wrap-around:
  - PCAddResult=0 (from PC=FFFFFFFC) is loaded as 0 with no special handling.
  - FetchCount wraps from FFFFFFFF to 0.
- PCResult[1:0] is always 00.

Test Plan:
- Reset=1 for 2 cycles, then release with an adder model PCAddResult=PCResult+4 and Instruction=PC^32'hA5A5A5A5. Required: PCResult steps 0,4,8,C; IF/ID after edge 1 = {4, A5A5A5A5, Valid=1}; FetchCount=3 after 3 edges.
- At PC=8, assert Stall for 2 cycles. Required: PCResult stays 8, IF/ID holds, FetchCount holds. On release, PC=C on the next edge.
- At PC=10, assert BranchTaken=1 with BranchTarget=40. Required: PCResult=40, IFID_Valid=0, IFID_Instruction=0. Next sequential edge: PC=44 and IFID_PCAdd=44.
- Assert Jump=1 (JumpTarget=100) together with BranchTaken=1 (BranchTarget=200) and Stall=1. Required: PCResult=100, IF/ID bubble.
- Assert Jump with JumpTarget=103. Required: PCResult=100, AlignFault=1 for one cycle, then 0.
- Force PC=FFFFFFFC and advance one edge. Required: PCResult=0. Separately, assert Reset mid-stall at PC=20. Required: PCResult=0, FetchCount=0, IFID_Valid=0.
